bus_io_port: RTL and testbench

Memory-mapped-free I/O responder for the 8-bit CPU: it answers the control unit's output-write and input-read strobes on the shared data bus. It buffers CPU output bytes in a small first-word-fall-through (FWFT) FIFO and drains them to an external device over a valid/ready handshake. It accepts input bytes from an external device into a one-entry holding register, which the CPU reads onto the bus. It sits beside the register file and ALU on the bus, and its strobes come straight from the control store outputs.

---
 rtl/bus_io_port_if.sv | 30 +++
 rtl/bus_io_port.sv | 72 +++++++
 tb/tb_bus_io_port.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_io_port_if.sv
// bus_io_port_if: CPU strobe/bus and external valid/ready signals of the I/O port
interface bus_io_port_if;
    logic       i_ctrlWrOut;
    logic       i_ctrlInNoe;
    logic [7:0] i_bus;
    logic [7:0] o_bus;
    logic       o_busOe;
    logic [7:0] o_outData;
    logic       o_outValid;
    logic       i_outReady;
    logic [7:0] i_inData;
    logic       i_inValid;
    logic       o_inReady;
    logic       o_inAvail;
    logic       o_outFull;
    logic       o_overflow;
    logic       o_underflow;

    modport slave (
        input  i_ctrlWrOut, i_ctrlInNoe, i_bus, i_outReady, i_inData, i_inValid,
        output o_bus, o_busOe, o_outData, o_outValid, o_inReady, o_inAvail,
               o_outFull, o_overflow, o_underflow
    );

    modport master (
        output i_ctrlWrOut, i_ctrlInNoe, i_bus, i_outReady, i_inData, i_inValid,
        input  o_bus, o_busOe, o_outData, o_outValid, o_inReady, o_inAvail,
               o_outFull, o_overflow, o_underflow
    );
endinterface

// File: rtl/bus_io_port.sv
// bus_io_port: CPU I/O responder with FWFT output FIFO and one-entry input holding register
module bus_io_port #(
    parameter int DEPTH = 4
) (
    input logic          i_clk,
    input logic          i_nReset,
    bus_io_port_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0] CNT_ONE = 1;
    localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [7:0]    mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    held_q, held_d;
    logic          avail_q, avail_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          pop, push, rd;

    // Next state: FIFO push/pop (push into a full FIFO is accepted when a pop frees a slot), holding register load/consume, sticky flags
    always_comb begin
        rd = ~bus.i_ctrlInNoe;
        pop = (count_q != '0) && bus.i_outReady;
        push = bus.i_ctrlWrOut && ((count_q != CNT_FULL) || pop);
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = bus.i_bus;
        wr_ptr_d = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d = (push && !pop) ? count_q + CNT_ONE : (pop && !push) ? count_q - CNT_ONE : count_q;
        overflow_d = overflow_q | (bus.i_ctrlWrOut & ~push);
        avail_d = (rd && avail_q) ? 1'b0 : (bus.i_inValid && !avail_q) ? 1'b1 : avail_q;
        held_d = (rd && avail_q) ? 8'h00 : (bus.i_inValid && !avail_q) ? bus.i_inData : held_q;
        underflow_d = underflow_q | (rd & ~avail_q);
    end

    // State registers, cleared asynchronously by reset
    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            held_q      <= 8'h00;
            avail_q     <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            held_q      <= held_d;
            avail_q     <= avail_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign bus.o_bus       = rd ? held_q : 8'h00;
    assign bus.o_busOe     = rd;
    assign bus.o_outData   = mem_q[rd_ptr_q];
    assign bus.o_outValid  = count_q != '0;
    assign bus.o_outFull   = count_q == CNT_FULL;
    assign bus.o_inReady   = ~avail_q;
    assign bus.o_inAvail   = avail_q;
    assign bus.o_overflow  = overflow_q;
    assign bus.o_underflow = underflow_q;
endmodule

// File: tb/tb_bus_io_port.sv
// tb_bus_io_port: randomized self-checking bench against a queue-based model of the I/O port
module tb_bus_io_port;
    localparam int DEPTH = 4;

    logic clk = 0;
    logic rst_n = 0;
    int checks = 0;
    int errors = 0;

    bus_io_port_if bif();
    bus_io_port #(.DEPTH(DEPTH)) dut (.i_clk(clk), .i_nReset(rst_n), .bus(bif));

    always #5 clk = ~clk;

    logic [7:0] q[$];
    logic [7:0] m_held;
    logic       m_avail, m_ovf, m_unf;

    task automatic model_clear();
        q.delete();
        m_held = 8'h00;
        m_avail = 0;
        m_ovf = 0;
        m_unf = 0;
    endtask

    task automatic apply(input logic wr, input logic [7:0] b, input logic noe, input logic rdy,
                         input logic iv, input logic [7:0] id);
        bif.i_ctrlWrOut = wr;
        bif.i_bus = b;
        bif.i_ctrlInNoe = noe;
        bif.i_outReady = rdy;
        bif.i_inValid = iv;
        bif.i_inData = id;
        #1;
    endtask

    task automatic tick();
        bit pre_avail;
        pre_avail = m_avail;
        if (q.size() != 0 && bif.i_outReady) void'(q.pop_front());
        if (bif.i_ctrlWrOut) begin
            if (q.size() < DEPTH) q.push_back(bif.i_bus);
            else m_ovf = 1;
        end
        if (!bif.i_ctrlInNoe && pre_avail) begin
            m_avail = 0;
            m_held = 8'h00;
        end else if (bif.i_inValid && !pre_avail) begin
            m_avail = 1;
            m_held = bif.i_inData;
        end
        if (!bif.i_ctrlInNoe && !pre_avail) m_unf = 1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        apply(0, 8'h00, 1, 0, 0, 8'h00);
        rst_n = 0;
        model_clear();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_reset();
        apply(1, 8'h5A, 0, 1, 1, 8'h66);
        rst_n = 0;
        model_clear();
        #1;
        checks++;
        if ({bif.o_outValid, bif.o_outFull, bif.o_inAvail, bif.o_inReady, bif.o_overflow, bif.o_underflow} !== 6'b000100) begin
            errors++;
            $display("FAIL reset_flags got %b exp 000100", {bif.o_outValid, bif.o_outFull, bif.o_inAvail, bif.o_inReady, bif.o_overflow, bif.o_underflow});
        end
        checks++;
        if (bif.o_outData !== 8'h00 || bif.o_bus !== 8'h00 || bif.o_busOe !== 1'b1) begin
            errors++;
            $display("FAIL reset_data got out=%h bus=%h oe=%b exp 00 00 1", bif.o_outData, bif.o_bus, bif.o_busOe);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bif.o_outValid !== 1'b0 || bif.o_inAvail !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold got valid=%b avail=%b exp 0 0", bif.o_outValid, bif.o_inAvail);
        end
        apply(0, 8'h00, 1, 0, 0, 8'h00);
        rst_n = 1;
    endtask

    task automatic test_single_write();
        do_reset();
        apply(1, 8'hA5, 1, 0, 0, 8'h00);
        tick();
        apply(0, 8'h00, 1, 0, 0, 8'h00);
        checks++;
        if (bif.o_outValid !== 1'b1 || bif.o_outData !== 8'hA5 || bif.o_outFull !== 1'b0) begin
            errors++;
            $display("FAIL single_write got v=%b d=%h f=%b exp 1 a5 0", bif.o_outValid, bif.o_outData, bif.o_outFull);
        end
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            apply(1, 8'(i), 1, 0, 0, 8'h00);
            tick();
            if (i == 4) begin
                checks++;
                if (bif.o_outFull !== 1'b1 || bif.o_overflow !== 1'b0) begin
                    errors++;
                    $display("FAIL fill_full got full=%b ovf=%b exp 1 0", bif.o_outFull, bif.o_overflow);
                end
            end
        end
        apply(0, 8'h00, 1, 0, 0, 8'h00);
        checks++;
        if (bif.o_overflow !== 1'b1 || bif.o_outFull !== 1'b1) begin
            errors++;
            $display("FAIL fill_overflow got ovf=%b full=%b exp 1 1", bif.o_overflow, bif.o_outFull);
        end
        for (int i = 1; i <= 4; i++) begin
            apply(0, 8'h00, 1, 1, 0, 8'h00);
            checks++;
            if (bif.o_outValid !== 1'b1 || bif.o_outData !== 8'(i)) begin
                errors++;
                $display("FAIL drain_order got v=%b d=%h exp 1 %h", bif.o_outValid, bif.o_outData, 8'(i));
            end
            tick();
        end
        checks++;
        if (bif.o_outValid !== 1'b0 || bif.o_overflow !== 1'b1) begin
            errors++;
            $display("FAIL drain_empty got v=%b ovf=%b exp 0 1", bif.o_outValid, bif.o_overflow);
        end
        apply(0, 8'h00, 1, 0, 0, 8'h00);
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            apply(1, 8'($urandom), 1, 0, 0, 8'h00);
            tick();
        end
        apply(1, 8'h77, 1, 1, 0, 8'h00);
        tick();
        apply(0, 8'h00, 1, 0, 0, 8'h00);
        checks++;
        if (bif.o_outFull !== 1'b1 || bif.o_overflow !== 1'b0 || q.size() != DEPTH) begin
            errors++;
            $display("FAIL full_push_pop got full=%b ovf=%b exp 1 0", bif.o_outFull, bif.o_overflow);
        end
        for (int i = 0; i < DEPTH; i++) begin
            apply(0, 8'h00, 1, 1, 0, 8'h00);
            checks++;
            if (bif.o_outData !== q[0] || (i == DEPTH - 1 && bif.o_outData !== 8'h77)) begin
                errors++;
                $display("FAIL full_drain got %h exp %h", bif.o_outData, q[0]);
            end
            tick();
        end
        apply(0, 8'h00, 1, 0, 0, 8'h00);
    endtask

    task automatic test_stream();
        int pushed = 0;
        int popped = 0;
        int cyc = 0;
        do_reset();
        while (popped < 20 && cyc < 400) begin
            logic rdy;
            logic wr;
            rdy = 1'($urandom);
            wr = (pushed < 20) && ((q.size() < DEPTH) || (rdy && q.size() != 0)) && 1'($urandom);
            apply(wr, 8'($urandom), 1, rdy, 0, 8'h00);
            if (q.size() != 0 && rdy) begin
                checks++;
                if (bif.o_outValid !== 1'b1 || bif.o_outData !== q[0]) begin
                    errors++;
                    $display("FAIL stream_pop got v=%b d=%h exp 1 %h", bif.o_outValid, bif.o_outData, q[0]);
                end
                popped++;
            end
            if (wr) pushed++;
            tick();
            cyc++;
        end
        checks++;
        if (popped != 20 || bif.o_overflow !== 1'b0 || bif.o_outValid !== 1'b0) begin
            errors++;
            $display("FAIL stream_done got popped=%0d ovf=%b v=%b exp 20 0 0", popped, bif.o_overflow, bif.o_outValid);
        end
        apply(0, 8'h00, 1, 0, 0, 8'h00);
    endtask

    task automatic test_input_read();
        do_reset();
        apply(0, 8'h00, 1, 0, 1, 8'h3C);
        tick();
        apply(0, 8'h00, 1, 0, 0, 8'h00);
        checks++;
        if (bif.o_inAvail !== 1'b1 || bif.o_inReady !== 1'b0 || bif.o_busOe !== 1'b0 || bif.o_bus !== 8'h00) begin
            errors++;
            $display("FAIL input_load got avail=%b rdy=%b oe=%b bus=%h exp 1 0 0 00", bif.o_inAvail, bif.o_inReady, bif.o_busOe, bif.o_bus);
        end
        apply(0, 8'h00, 0, 0, 1, 8'h99);
        checks++;
        if (bif.o_bus !== 8'h3C || bif.o_busOe !== 1'b1) begin
            errors++;
            $display("FAIL input_read got bus=%h oe=%b exp 3c 1", bif.o_bus, bif.o_busOe);
        end
        tick();
        apply(0, 8'h00, 1, 0, 0, 8'h00);
        checks++;
        if (bif.o_inAvail !== 1'b0 || bif.o_inReady !== 1'b1 || bif.o_underflow !== 1'b0) begin
            errors++;
            $display("FAIL input_consume got avail=%b rdy=%b unf=%b exp 0 1 0", bif.o_inAvail, bif.o_inReady, bif.o_underflow);
        end
    endtask

    task automatic test_underflow();
        do_reset();
        apply(0, 8'h00, 0, 0, 0, 8'h00);
        checks++;
        if (bif.o_bus !== 8'h00 || bif.o_busOe !== 1'b1) begin
            errors++;
            $display("FAIL underflow_bus got bus=%h oe=%b exp 00 1", bif.o_bus, bif.o_busOe);
        end
        tick();
        apply(0, 8'h00, 1, 0, 0, 8'h00);
        checks++;
        if (bif.o_underflow !== 1'b1 || bif.o_inAvail !== 1'b0) begin
            errors++;
            $display("FAIL underflow_flag got unf=%b avail=%b exp 1 0", bif.o_underflow, bif.o_inAvail);
        end
    endtask

    task automatic test_reset_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            apply(1, 8'hC0 + 8'(i), 1, 0, 1, 8'h44);
            tick();
        end
        apply(1, 8'hEE, 0, 0, 0, 8'h00);
        tick();
        apply(0, 8'h00, 1, 0, 0, 8'h00);
        @(negedge clk);
        rst_n = 0;
        model_clear();
        #1;
        checks++;
        if ({bif.o_outValid, bif.o_outFull, bif.o_inAvail, bif.o_inReady, bif.o_overflow, bif.o_underflow} !== 6'b000100 || bif.o_outData !== 8'h00) begin
            errors++;
            $display("FAIL reset_full got flags=%b data=%h exp 000100 00", {bif.o_outValid, bif.o_outFull, bif.o_inAvail, bif.o_inReady, bif.o_overflow, bif.o_underflow}, bif.o_outData);
        end
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            apply(1'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 8'($urandom));
            checks++;
            if (bif.o_outValid !== (q.size() != 0) || bif.o_outFull !== (q.size() == DEPTH) ||
                (q.size() != 0 && bif.o_outData !== q[0]) || bif.o_inAvail !== m_avail ||
                bif.o_inReady !== !m_avail || bif.o_overflow !== m_ovf || bif.o_underflow !== m_unf ||
                bif.o_busOe !== !bif.i_ctrlInNoe || bif.o_bus !== ((!bif.i_ctrlInNoe && m_avail) ? m_held : 8'h00)) begin
                errors++;
                $display("FAIL random c=%0d got v=%b f=%b d=%h a=%b o=%b u=%b bus=%h exp v=%b f=%b a=%b o=%b u=%b",
                         c, bif.o_outValid, bif.o_outFull, bif.o_outData, bif.o_inAvail, bif.o_overflow, bif.o_underflow, bif.o_bus,
                         q.size() != 0, q.size() == DEPTH, m_avail, m_ovf, m_unf);
            end
            tick();
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_write();
        test_fill_overflow();
        test_full_push_pop();
        test_stream();
        test_input_read();
        test_underflow();
        test_reset_full();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
